// File: rtl/writeback_pkg.sv
// Writeback encodings, buffered entry layout and load-lane extraction.
// Entry fields are sized for the widest supported datapath; narrower instances zero-extend on push and truncate on read.
package writeback_pkg;

    localparam int MAX_DATA_W = 256;
    localparam int MAX_REG_AW = 8;
    localparam int MAX_OFF_W  = 5;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ALU = 2'b01,
        OP_CMP = 2'b10,
        OP_LD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10,
        LD_RSVD = 2'b11
    } ld_size_e;

    typedef struct packed {
        op_e                   op;
        logic [MAX_REG_AW-1:0] rd;
        logic [MAX_DATA_W-1:0] val;
        logic [MAX_DATA_W-1:0] cpsr;
    } entry_t;

    // Halves are aligned: the low offset bit never selects a lane.
    function automatic logic [MAX_DATA_W-1:0] ld_extract(
        input logic [MAX_DATA_W-1:0] word,
        input ld_size_e              size,
        input logic                  sgn,
        input logic [MAX_OFF_W-1:0]  off
    );
        logic [15:0] half;
        logic [7:0]  byt;
        half = word[{off[MAX_OFF_W-1:1], 4'b0000} +: 16];
        byt  = word[{off, 3'b000} +: 8];
        case (size)
            LD_HALF: ld_extract = {{(MAX_DATA_W-16){sgn & half[15]}}, half};
            LD_BYTE: ld_extract = {{(MAX_DATA_W-8){sgn & byt[7]}}, byt};
            default: ld_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small in-order entry buffer exposing every slot for hazard lookup; head visible one cycle after push.
// push_rdy is plain not-full (low during reset), so a same-cycle pop never frees a slot early.
module wb_skid_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0]
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_vld,
    output logic                 push_rdy,
    input  entry_t               push_dat,
    input  logic                 pop_rdy,
    output logic                 head_vld,
    output entry_t               head_dat,
    output logic   [DEPTH-1:0]   ent_vld,
    output entry_t [DEPTH-1:0]   ent_dat
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW:0]        count;
    logic [DEPTH-1:0]   vld;
    entry_t [DEPTH-1:0] mem;
    logic               do_push;
    logic               do_pop;
    logic [DEPTH-1:0]   push_mask;
    logic [DEPTH-1:0]   pop_mask;

    assign push_rdy  = (count != (PW+1)'(DEPTH)) && !reset;
    assign head_vld  = vld[rd_ptr];
    assign head_dat  = mem[rd_ptr];
    assign ent_vld   = vld;
    assign ent_dat   = mem;
    assign do_push   = push_vld && push_rdy;
    assign do_pop    = pop_rdy && head_vld;
    assign push_mask = do_push ? (DEPTH'(1) << wr_ptr) : '0;
    assign pop_mask  = do_pop  ? (DEPTH'(1) << rd_ptr) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PW+1)'(1);
            end
            vld <= (vld & ~pop_mask) | push_mask;
        end
    end

endmodule

// File: rtl/writeback_pipe.sv
// Writeback stage: buffers memory-stage results, extracts loads at push, drives RF/CPSR write ports from the head.
// Outputs are combinational from the head (entry visible the cycle after push); rf_ready low stalls the head, in_ready = not-full.
module writeback_pipe
    import writeback_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    op_sel,
    input  logic [REG_AW-1:0]             rd_num_passthrough,
    input  logic [DATA_W-1:0]             result,
    input  logic [DATA_W-1:0]             cpsr_passthrough,
    input  logic [DATA_W-1:0]             dmem_val_passthrough,
    input  logic [1:0]                    ld_size,
    input  logic                          ld_signed,
    input  logic [$clog2(DATA_W/8)-1:0]   byte_off,
    input  logic                          rf_ready,
    output logic [REG_AW-1:0]             rd_num,
    output logic                          rd_write_en,
    output logic [DATA_W-1:0]             rd_val,
    output logic                          cpsr_write_en,
    output logic [DATA_W-1:0]             cpsr_out,
    input  logic [REG_AW-1:0]             chk_num,
    output logic                          chk_hit,
    output logic [CNT_W-1:0]              retired_count
);

    op_e                in_op;
    entry_t             push_ent;
    logic               head_vld;
    entry_t             head_dat;
    logic [DEPTH-1:0]   ent_vld;
    entry_t [DEPTH-1:0] ent_dat;
    logic               head_writes_rd;
    logic               unused_bits;

    assign in_op = op_e'(op_sel);

    // Only the field the op will consume is captured; the rest stay zero.
    always_comb begin
        push_ent    = '0;
        push_ent.op = in_op;
        push_ent.rd = MAX_REG_AW'(rd_num_passthrough);
        case (in_op)
            OP_ALU:  push_ent.val  = MAX_DATA_W'(result);
            OP_LD:   push_ent.val  = ld_extract(MAX_DATA_W'(dmem_val_passthrough),
                                                ld_size_e'(ld_size), ld_signed,
                                                MAX_OFF_W'(byte_off));
            OP_CMP:  push_ent.cpsr = MAX_DATA_W'(cpsr_passthrough);
            default: ;
        endcase
    end

    wb_skid_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (push_ent),
        .pop_rdy  (rf_ready),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .ent_vld  (ent_vld),
        .ent_dat  (ent_dat)
    );

    assign head_writes_rd = head_vld && (head_dat.op == OP_ALU || head_dat.op == OP_LD);
    assign rd_write_en    = head_writes_rd && rf_ready;
    assign cpsr_write_en  = head_vld && (head_dat.op == OP_CMP) && rf_ready;
    assign rd_num         = head_vld ? head_dat.rd[REG_AW-1:0]     : '0;
    assign rd_val         = head_vld ? head_dat.val[DATA_W-1:0]    : '0;
    assign cpsr_out       = head_vld ? head_dat.cpsr[DATA_W-1:0]   : '0;
    assign unused_bits    = ^{head_dat, ent_dat};

    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_dat[i].op == OP_ALU || ent_dat[i].op == OP_LD) &&
                ent_dat[i].rd == MAX_REG_AW'(chk_num)) begin
                chk_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
        end else if (rd_write_en || cpsr_write_en) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe: load-extract vector table plus hand-written stall, NOP and reset sequences.
module tb_writeback_pipe;

    localparam logic [1:0] NOP = 2'b00, ALU = 2'b01, CMP = 2'b10, LD = 2'b11;
    localparam logic [1:0] SZ_W = 2'b00, SZ_H = 2'b01, SZ_B = 2'b10, SZ_R = 2'b11;
    localparam logic [31:0] DMEM = 32'h80F0_7F81;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, ld_signed, rf_ready;
    logic [1:0]  op_sel, ld_size, byte_off;
    logic [3:0]  rd_num_passthrough, rd_num, chk_num;
    logic [31:0] result, cpsr_passthrough, dmem_val_passthrough, rd_val, cpsr_out;
    logic        rd_write_en, cpsr_write_en, chk_hit;
    logic [15:0] retired_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    writeback_pipe #(.DATA_W(32), .REG_AW(4), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd_num_passthrough(rd_num_passthrough), .result(result),
        .cpsr_passthrough(cpsr_passthrough), .dmem_val_passthrough(dmem_val_passthrough),
        .ld_size(ld_size), .ld_signed(ld_signed), .byte_off(byte_off), .rf_ready(rf_ready),
        .rd_num(rd_num), .rd_write_en(rd_write_en), .rd_val(rd_val),
        .cpsr_write_en(cpsr_write_en), .cpsr_out(cpsr_out), .chk_num(chk_num),
        .chk_hit(chk_hit), .retired_count(retired_count)
    );

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  rd;
        logic [31:0] res;
        logic [31:0] cp;
        logic [31:0] dm;
        logic [1:0]  sz;
        logic        sg;
        logic [1:0]  off;
        logic        rwe;
        logic        cwe;
        logic [31:0] val;
    } vec_t;

    vec_t tv [12];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] rd,
                         input logic [31:0] res, input logic [31:0] cp, input logic [31:0] dm,
                         input logic [1:0] sz, input logic sg, input logic [1:0] off);
        in_valid             = v;
        op_sel               = op;
        rd_num_passthrough   = rd;
        result               = res;
        cpsr_passthrough     = cp;
        dmem_val_passthrough = dm;
        ld_size              = sz;
        ld_signed            = sg;
        byte_off             = off;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{LD,  4'd1,  32'd0, 32'd0, DMEM, SZ_B, 1'b1, 2'd0, 1'b1, 1'b0, 32'hFFFF_FF81};
        tv[1]  = '{LD,  4'd2,  32'd0, 32'd0, DMEM, SZ_B, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0000_0081};
        tv[2]  = '{LD,  4'd3,  32'd0, 32'd0, DMEM, SZ_H, 1'b1, 2'd3, 1'b1, 1'b0, 32'hFFFF_80F0};
        tv[3]  = '{LD,  4'd4,  32'd0, 32'd0, DMEM, SZ_W, 1'b1, 2'd0, 1'b1, 1'b0, 32'h80F0_7F81};
        tv[4]  = '{LD,  4'd5,  32'd0, 32'd0, DMEM, SZ_H, 1'b0, 2'd1, 1'b1, 1'b0, 32'h0000_7F81};
        tv[5]  = '{LD,  4'd6,  32'd0, 32'd0, DMEM, SZ_B, 1'b1, 2'd2, 1'b1, 1'b0, 32'hFFFF_FFF0};
        tv[6]  = '{LD,  4'd7,  32'd0, 32'd0, DMEM, SZ_B, 1'b1, 2'd1, 1'b1, 1'b0, 32'h0000_007F};
        tv[7]  = '{LD,  4'd8,  32'd0, 32'd0, DMEM, SZ_R, 1'b1, 2'd0, 1'b1, 1'b0, 32'h80F0_7F81};
        tv[8]  = '{LD,  4'd10, 32'd0, 32'd0, DMEM, SZ_H, 1'b0, 2'd2, 1'b1, 1'b0, 32'h0000_80F0};
        tv[9]  = '{ALU, 4'd9,  32'hDEAD_BEEF, 32'd0, DMEM, SZ_B, 1'b1, 2'd1, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tv[10] = '{CMP, 4'd11, 32'd0, 32'h6000_0000, DMEM, SZ_W, 1'b0, 2'd0, 1'b0, 1'b1, 32'h6000_0000};
        tv[11] = '{NOP, 4'd12, 32'h1234, 32'h5678, DMEM, SZ_W, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0};

        reset = 1'b1;
        rf_ready = 1'b0;
        chk_num = 4'd0;
        drive(1'b0, NOP, 4'd0, 32'd0, 32'd0, 32'd0, SZ_W, 1'b0, 2'd0);
        @(negedge clk);
        check1("rst_in_ready_low", in_ready, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check1("post_rst_in_ready", in_ready, 1'b1);
        check1("post_rst_rd_we", rd_write_en, 1'b0);
        check1("post_rst_cpsr_we", cpsr_write_en, 1'b0);
        check32("post_rst_rd_val", rd_val, 32'd0);
        check32("post_rst_cpsr_out", cpsr_out, 32'd0);
        check32("post_rst_rd_num", 32'(rd_num), 32'd0);
        check1("post_rst_chk_hit", chk_hit, 1'b0);
        check32("post_rst_count", 32'(retired_count), 32'd0);
        tick();

        // 16 back-to-back ALU writes, one per cycle
        rf_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(1'b1, ALU, 4'(i), 32'(i), 32'd0, 32'd0, SZ_W, 1'b0, 2'd0);
            else        in_valid = 1'b0;
            @(negedge clk);
            check1($sformatf("alu%0d_in_ready", i), in_ready, 1'b1);
            if (i == 0) begin
                check1("alu_empty_no_we", rd_write_en, 1'b0);
            end else begin
                check1($sformatf("alu%0d_we", i - 1), rd_write_en, 1'b1);
                check32($sformatf("alu%0d_rd_num", i - 1), 32'(rd_num), 32'(i - 1));
                check32($sformatf("alu%0d_rd_val", i - 1), rd_val, 32'(i - 1));
                exp_cnt++;
            end
            tick();
        end
        @(negedge clk);
        check32("alu16_count", 32'(retired_count), 32'd16);
        tick();

        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(1'b1, CMP, 4'd2, 32'd0, 32'(i), 32'd0, SZ_W, 1'b0, 2'd0);
            else        in_valid = 1'b0;
            @(negedge clk);
            check1($sformatf("cmp%0d_rd_we", i), rd_write_en, 1'b0);
            if (i > 0) begin
                check1($sformatf("cmp%0d_cpsr_we", i - 1), cpsr_write_en, 1'b1);
                check32($sformatf("cmp%0d_cpsr", i - 1), cpsr_out, 32'(i - 1));
                exp_cnt++;
            end
            tick();
        end
        @(negedge clk);
        check32("cmp16_count", 32'(retired_count), 32'(exp_cnt));
        tick();

        for (int k = 0; k < 12; k++) begin
            drive(1'b1, tv[k].op, tv[k].rd, tv[k].res, tv[k].cp, tv[k].dm, tv[k].sz, tv[k].sg, tv[k].off);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            check1($sformatf("vec%0d_rd_we", k), rd_write_en, tv[k].rwe);
            check1($sformatf("vec%0d_cpsr_we", k), cpsr_write_en, tv[k].cwe);
            if (tv[k].rwe) begin
                check32($sformatf("vec%0d_rd_val", k), rd_val, tv[k].val);
                check32($sformatf("vec%0d_rd_num", k), 32'(rd_num), 32'(tv[k].rd));
            end
            if (tv[k].cwe) check32($sformatf("vec%0d_cpsr", k), cpsr_out, tv[k].val);
            if (tv[k].rwe || tv[k].cwe) exp_cnt++;
            tick();
            @(negedge clk);
            check32($sformatf("vec%0d_count", k), 32'(retired_count), 32'(exp_cnt));
            tick();
        end

        // Backpressure: fill with rf_ready low, third offer waits, then drain in order
        rf_ready = 1'b0;
        drive(1'b1, ALU, 4'd3, 32'h33, 32'd0, 32'd0, SZ_W, 1'b0, 2'd0);
        @(negedge clk);
        check1("bp_a_in_ready", in_ready, 1'b1);
        tick();
        drive(1'b1, ALU, 4'd5, 32'h55, 32'd0, 32'd0, SZ_W, 1'b0, 2'd0);
        chk_num = 4'd3;
        @(negedge clk);
        check1("bp_b_in_ready", in_ready, 1'b1);
        check1("bp_stall_no_we", rd_write_en, 1'b0);
        check1("bp_hit_r3", chk_hit, 1'b1);
        tick();
        drive(1'b1, LD, 4'd7, 32'd0, 32'd0, 32'h77, SZ_W, 1'b0, 2'd0);
        chk_num = 4'd5;
        @(negedge clk);
        check1("bp_full_in_ready", in_ready, 1'b0);
        check1("bp_hit_r5", chk_hit, 1'b1);
        chk_num = 4'd7;
        #1;
        check1("bp_miss_r7", chk_hit, 1'b0);
        tick();
        rf_ready = 1'b1;
        @(negedge clk);
        check1("bp_no_bypass", in_ready, 1'b0);
        check1("bp_a_we", rd_write_en, 1'b1);
        check32("bp_a_val", rd_val, 32'h33);
        check32("bp_a_rd", 32'(rd_num), 32'd3);
        tick();
        @(negedge clk);
        check1("bp_reopen", in_ready, 1'b1);
        check32("bp_b_val", rd_val, 32'h55);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check32("bp_c_val", rd_val, 32'h77);
        check32("bp_c_rd", 32'(rd_num), 32'd7);
        tick();
        exp_cnt += 3;
        @(negedge clk);
        check1("bp_drained_we", rd_write_en, 1'b0);
        check32("bp_count", 32'(retired_count), 32'(exp_cnt));
        tick();

        // NOP between two ALU writes takes a cycle without a strobe
        drive(1'b1, ALU, 4'd1, 32'hA1, 32'd0, 32'd0, SZ_W, 1'b0, 2'd0);
        tick();
        drive(1'b1, NOP, 4'd2, 32'hFF, 32'd0, 32'd0, SZ_W, 1'b0, 2'd0);
        @(negedge clk);
        check32("nop_pre_val", rd_val, 32'hA1);
        tick();
        drive(1'b1, ALU, 4'd3, 32'hA3, 32'd0, 32'd0, SZ_W, 1'b0, 2'd0);
        @(negedge clk);
        check1("nop_rd_we", rd_write_en, 1'b0);
        check1("nop_cpsr_we", cpsr_write_en, 1'b0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check1("nop_post_we", rd_write_en, 1'b1);
        check32("nop_post_val", rd_val, 32'hA3);
        tick();
        exp_cnt += 2;
        @(negedge clk);
        check32("nop_count", 32'(retired_count), 32'(exp_cnt));
        tick();

        // Reset while full discards the buffered entries
        rf_ready = 1'b0;
        drive(1'b1, ALU, 4'd5, 32'h55, 32'd0, 32'd0, SZ_W, 1'b0, 2'd0);
        tick();
        drive(1'b1, ALU, 4'd6, 32'h66, 32'd0, 32'd0, SZ_W, 1'b0, 2'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check1("rf_full", in_ready, 1'b0);
        reset = 1'b1;
        #1;
        check1("rf_rst_in_ready", in_ready, 1'b0);
        tick();
        reset = 1'b0;
        rf_ready = 1'b1;
        chk_num = 4'd6;
        @(negedge clk);
        check1("rf_no_rd_we", rd_write_en, 1'b0);
        check1("rf_no_cpsr_we", cpsr_write_en, 1'b0);
        check1("rf_in_ready", in_ready, 1'b1);
        check32("rf_count", 32'(retired_count), 32'd0);
        check1("rf_no_hit", chk_hit, 1'b0);
        tick();
        @(negedge clk);
        check1("rf_still_no_we", rd_write_en, 1'b0);
        check32("rf_count_hold", 32'(retired_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_pipe.md
WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; multiple of 8, at least 32.
REQ-002 SHALL have parameter REG_AW, default 4, register-number width.
REQ-003 SHALL have parameter DEPTH, default 2, buffer entries; power of two, at least 2.
REQ-004 SHALL have parameter CNT_W, default 16, retire-counter width.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  memory stage offers an entry.
REQ-009 in_ready  out  1  buffer can accept an entry.
REQ-010 op_sel  in  2  operation: 00 NOP, 01 ALU, 10 CMP, 11 LD.
REQ-011 rd_num_passthrough  in  REG_AW  destination register.
REQ-012 result  in  DATA_W  ALU result.
REQ-013 cpsr_passthrough  in  DATA_W  flags from a compare.
REQ-014 dmem_val_passthrough  in  DATA_W  load word from data memory.
REQ-015 ld_size  in  2  load size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-016 ld_signed  in  1  sign-extend a sub-word load.
REQ-017 byte_off  in  $clog2(DATA_W/8)  load byte offset.
REQ-018 rf_ready  in  1  register file accepts a write this cycle.
REQ-019 rd_num  out  REG_AW  write-port register number.
REQ-020 rd_write_en  out  1  register write strobe.
REQ-021 rd_val  out  DATA_W  register write data.
REQ-022 cpsr_write_en  out  1  CPSR write strobe.
REQ-023 cpsr_out  out  DATA_W  CPSR write data.
REQ-024 chk_num  in  REG_AW  hazard-query register.
REQ-025 chk_hit  out  1  a buffered entry will write chk_num.
REQ-026 retired_count  out  CNT_W  count of committed writes.

Function
REQ-027 in_ready SHALL equal not-full; there is no bypass while full, even if a pop occurs in the same cycle.
REQ-028 An entry SHALL be pushed when in_valid and in_ready are both high at a rising edge.
REQ-029 The LD value SHALL be extracted at push.
- Half: selected by the upper offset bits; byte_off bit 0 is ignored.
- Byte: selected by byte_off.
- Sign- or zero-extended to DATA_W per ld_signed.
REQ-030 Outputs SHALL be driven combinationally from the head entry; an entry pushed into an empty buffer at edge N SHALL be at the head in cycle N+1.
REQ-031 rd_write_en SHALL be high when: head valid, op ALU or LD, and rf_ready.
REQ-032 cpsr_write_en SHALL be high when: head valid, op CMP, and rf_ready.
REQ-033 rd_val SHALL be result for ALU and the extracted load value for LD.
REQ-034 When no head is valid, rd_val, cpsr_out and rd_num SHALL be 0.
REQ-035 The head SHALL pop when head valid and rf_ready (NOP included); push and pop in the same cycle SHALL keep occupancy unchanged.
REQ-036 retired_count SHALL increment by 1 on each cycle where rd_write_en or cpsr_write_en is high, and wrap modulo 2^CNT_W.
REQ-037 chk_hit SHALL be combinational and high if any valid entry (head included) has op ALU or LD and rd_num equal to chk_num.
REQ-038 Entries SHALL commit strictly in push order; with rf_ready held high, throughput SHALL be one entry per cycle.

Reset
REQ-039 While reset is high at a rising edge, the block SHALL empty the buffer (discarding in-flight entries), zero the pointers and retired_count, and hold in_ready at 0 for that cycle.
REQ-040 After reset all outputs SHALL be 0 except in_ready, which SHALL be 1.

Structure
REQ-041 Package writeback_pkg SHALL hold the op_sel and ld_size encodings, the entry struct {op, rd, val, cpsr}, and a load-extract function.
REQ-042 Buffering SHALL live in one sub-module, wb_skid_fifo (DEPTH, entry type); chk_hit SHALL be computed from its exposed valid vector and entries.

Verification
REQ-043 Reset, then 16 ALU pushes (rd=i, result=i) with rf_ready=1 -> writes r0..r15 with value i, one per cycle, first write 1 cycle after first push; retired_count=16.
REQ-044 16 CMP pushes (cpsr=i) -> cpsr_write_en each cycle with cpsr_out=i; rd_write_en stays 0.
REQ-045 LD with dmem=0x80F0_7F81:
- byte, off=0, signed -> 0xFFFF_FF81.
- byte, off=0, unsigned -> 0x0000_0081.
- half, off=3, signed -> 0xFFFF_80F0.
- word -> 0x80F0_7F81.
REQ-046 rf_ready=0, push 3 entries -> in_ready drops after 2 (DEPTH=2), third held; chk_hit=1 for a buffered rd; release -> in-order commits.
REQ-047 Buffer full, assert reset for one cycle -> no strobes after reset, in_ready=1, retired_count=0.
REQ-048 NOP between two ALU entries -> NOP consumes one cycle with no strobe and no count.
